// File: rtl/revo_decoder.sv
// -----------------------------------------------------------------------------
// revo_decoder
//
// Recovers a once-per-revolution marker from an encoded clock line. The line
// is a 50% duty clock at 1/4 of the sampling clock; a revolution marker is a
// period whose high half is suppressed. The decoder finds the sample phase at
// which a full period reads 0011, verifies it for LOCK_COUNT periods, then
// strobes revo once for each suppressed period while locked.
//
// Ports
//   clock             sampling clock (4x the encoded clock), only clock
//   reset             asynchronous, active-high
//   encoded_in        raw encoded line (asynchronous to clock)
//   revo              one-cycle strobe per decoded revolution marker
//   locked            high while in LOCKED
//   phase             sample phase at which periods are evaluated
//   error_count       saturating count of bad windows seen while locked
//   revo_period       encoded periods between the last two revos
//   revo_period_valid one-cycle strobe when revo_period updates
//
// Build option
//   REVO_PERIOD_MEASURE_EN  when defined, revo_period / revo_period_valid are
//                           driven by a per-evaluation period counter; when
//                           undefined they are tied to 0.
// -----------------------------------------------------------------------------
module revo_decoder #(
   parameter int SAMPLES_PER_PERIOD = 4,
   parameter int LOCK_COUNT         = 64,
   parameter int MAX_ERRORS         = 4,
   parameter int PERIOD_WIDTH       = 24
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    encoded_in,
   output logic                    revo,
   output logic                    locked,
   output logic [1:0]              phase,
   output logic [7:0]              error_count,
   output logic [PERIOD_WIDTH-1:0] revo_period,
   output logic                    revo_period_valid
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(MAX_ERRORS + 1);

   localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
   localparam logic [BW-1:0] BAD_LAST  = BW'(MAX_ERRORS - 1);

   // Window values seen at the evaluation phase. Oldest sample is the MSB, so
   // a healthy period (low half then high half) reads 0011.
   localparam logic [SAMPLES_PER_PERIOD-1:0] WIN_GOOD = 4'b0011;
   localparam logic [SAMPLES_PER_PERIOD-1:0] WIN_MISS = 4'b0000;

   localparam logic [1:0] S_SEARCH = 2'd0;
   localparam logic [1:0] S_VERIFY = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   logic                          sync1;
   logic                          sync2;
   logic [SAMPLES_PER_PERIOD-1:0] window;
   logic [1:0]                    cnt;
   logic [1:0]                    state;
   logic [GW-1:0]                 good_cnt;
   logic [BW-1:0]                 bad_cnt;
   logic                          miss_seen;

   logic eval_now;
   logic win_good;
   logic win_miss;
   logic lock_enter;
   logic revo_fire;

   // ---------------------------------------------------------------------------
   // Sampling front end: 2-flop synchronizer, shift window, free-running phase
   // counter. Everything downstream looks only at the synchronized sample.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         window <= '0;
         cnt    <= 2'd0;
      end else begin
         sync1  <= encoded_in;
         sync2  <= sync1;
         window <= {window[SAMPLES_PER_PERIOD-2:0], sync2};
         cnt    <= cnt + 2'd1;
      end
   end

   assign eval_now = (cnt == phase);
   assign win_good = (window == WIN_GOOD);
   assign win_miss = (window == WIN_MISS);

   // Last required good evaluation in VERIFY, and the first MISSING of a pair
   // in LOCKED; shared by the FSM and the period counter.
   assign lock_enter = (state == S_VERIFY) && eval_now && win_good &&
                       (good_cnt == GOOD_LAST);
   assign revo_fire  = (state == S_LOCKED) && eval_now && win_miss && !miss_seen;

   // ---------------------------------------------------------------------------
   // Acquisition / tracking FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_SEARCH;
         phase       <= 2'd0;
         good_cnt    <= '0;
         bad_cnt     <= '0;
         miss_seen   <= 1'b0;
         revo        <= 1'b0;
         error_count <= 8'd0;
      end else begin
         // revo is a registered copy of the decision, so it lands exactly one
         // cycle after the evaluation that found the marker.
         revo <= revo_fire;

         case (state)
            S_SEARCH: begin
               // Any cycle showing a full good period defines the phase.
               if (win_good) begin
                  phase     <= cnt;
                  good_cnt  <= '0;
                  miss_seen <= 1'b0;
                  state     <= S_VERIFY;
               end
            end

            S_VERIFY: begin
               if (eval_now) begin
                  if (win_good) begin
                     miss_seen <= 1'b0;
                     if (lock_enter) begin
                        bad_cnt <= '0;
                        state   <= S_LOCKED;
                     end else begin
                        good_cnt <= good_cnt + GW'(1);
                     end
                  end else if (win_miss) begin
                     // A single marker during verification is legitimate;
                     // two in a row means the line stopped.
                     if (miss_seen) state <= S_SEARCH;
                     else           miss_seen <= 1'b1;
                  end else begin
                     state <= S_SEARCH;
                  end
               end
            end

            S_LOCKED: begin
               if (eval_now) begin
                  if (win_good) begin
                     bad_cnt   <= '0;
                     miss_seen <= 1'b0;
                  end else if (win_miss) begin
                     // Second consecutive MISSING: line is dead, drop lock
                     // without a revo.
                     if (miss_seen) state <= S_SEARCH;
                     else           miss_seen <= 1'b1;
                  end else begin
                     miss_seen <= 1'b0;
                     // Counted even when this BAD is the one that drops lock.
                     if (error_count != 8'hFF) error_count <= error_count + 8'd1;
                     if (bad_cnt == BAD_LAST) state <= S_SEARCH;
                     else                     bad_cnt <= bad_cnt + BW'(1);
                  end
               end
            end

            default: state <= S_SEARCH;
         endcase
      end
   end

   assign locked = (state == S_LOCKED);

   // ---------------------------------------------------------------------------
   // Revolution period measurement
   // ---------------------------------------------------------------------------
`ifdef REVO_PERIOD_MEASURE_EN
   logic [PERIOD_WIDTH-1:0] period_cnt;
   logic                    first_revo;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         period_cnt        <= '0;
         first_revo        <= 1'b1;
         revo_period       <= '0;
         revo_period_valid <= 1'b0;
      end else begin
         revo_period_valid <= 1'b0;
         if (lock_enter) begin
            period_cnt <= '0;
            first_revo <= 1'b1;
         end else if (revo_fire) begin
            // The marker evaluation itself starts the next interval, hence
            // the restart at 1 rather than 0.
            revo_period       <= period_cnt;
            revo_period_valid <= !first_revo;
            first_revo        <= 1'b0;
            period_cnt        <= PERIOD_WIDTH'(1);
         end else if ((state == S_LOCKED) && eval_now && (period_cnt != '1)) begin
            period_cnt <= period_cnt + PERIOD_WIDTH'(1);
         end
      end
   end
`else
   assign revo_period       = '0;
   assign revo_period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_revo_decoder.sv
// -----------------------------------------------------------------------------
// tb_revo_decoder
//
// Drives encoded periods sample by sample (oldest sample first) and checks
// lock state, error counting, phase selection and revo timing. Every marker
// period driven while the bench expects lock pushes an expected revo (cycle,
// period-valid, period) onto a scoreboard; a negedge monitor pops and
// compares each revo the decoder produces.
// -----------------------------------------------------------------------------
module tb_revo_decoder;

   localparam int PW  = 24;
   // Cycles from driving the first suppressed sample to revo being visible:
   // 2 synchronizer flops, 2 more samples to complete the window, 1 register.
   localparam int LAT = 5;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          encoded_in = 1'b0;
   logic          revo;
   logic          locked;
   logic [1:0]    phase;
   logic [7:0]    error_count;
   logic [PW-1:0] revo_period;
   logic          revo_period_valid;

   revo_decoder #(.PERIOD_WIDTH(PW)) dut (
      .clock             (clock),
      .reset             (reset),
      .encoded_in        (encoded_in),
      .revo              (revo),
      .locked            (locked),
      .phase             (phase),
      .error_count       (error_count),
      .revo_period       (revo_period),
      .revo_period_valid (revo_period_valid)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int revo_total = 0;

   typedef struct {
      int            cyc;
      logic          valid;
      logic [PW-1:0] per;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      string      name;
      logic [3:0] pat;
      int         n;
      int         extra;
      logic       exp_locked;
      int         exp_err;
      int         exp_revos;
      int         exp_phase;
   } vec_t;

   // Bench-side model state used to decide when a marker should produce revo.
   logic          mlocked = 1'b0;
   logic          prev_missing = 1'b0;
   logic          nxt_valid = 1'b0;
   logic [PW-1:0] nxt_per = '0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      encoded_in = b;
      @(posedge clock);
      #1;
   endtask

   task automatic send_period(input logic [3:0] pat);
      for (int i = 3; i >= 0; i--) begin
         if (i == 1 && pat == 4'b0000 && mlocked && !prev_missing) begin
            exp_t e;
            e.cyc   = cyc + LAT;
            e.valid = nxt_valid;
            e.per   = nxt_per;
            sb.push_back(e);
         end
         send_bit(pat[i]);
      end
      prev_missing = (pat == 4'b0000);
   endtask

   // n periods of pat, then one clean period so the last pattern evaluation
   // has settled before the checks.
   task automatic run_rec(input vec_t r);
      int r0;
      r0 = revo_total;
      for (int i = 0; i < r.extra; i++) send_bit(1'b0);
      for (int i = 0; i < r.n; i++) send_period(r.pat);
      send_period(4'b0011);
      check({r.name, "_locked"}, locked, r.exp_locked);
      check({r.name, "_err"}, error_count, r.exp_err);
      check({r.name, "_revos"}, revo_total - r0, r.exp_revos);
      check({r.name, "_sb_left"}, sb.size(), 0);
      if (r.exp_phase >= 0) check({r.name, "_phase"}, phase, r.exp_phase);
      sb.delete();
      mlocked = r.exp_locked;
   endtask

   // Revo monitor / scoreboard consumer.
   initial begin
      forever begin
         @(negedge clock);
         if (revo_period_valid === 1'b1) check("valid_with_revo", revo, 1);
         if (revo === 1'b1) begin
            revo_total++;
            check("revo_in_locked", locked, 1);
            check("revo_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check("revo_latency", cyc, e.cyc);
               check("revo_period_valid", revo_period_valid, e.valid);
`ifdef REVO_PERIOD_MEASURE_EN
               if (e.valid) check("revo_period", revo_period, e.per);
`else
               check("revo_period_zero", revo_period, 0);
`endif
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $fatal(1);
   end

   vec_t tbl[13];

   initial begin
      vec_t tmp;
      int   r0;

      tbl[0]  = '{"acq60",    4'b0011, 59, 0, 1'b0, 0,  0, -1};
      tbl[1]  = '{"acq66",    4'b0011,  5, 0, 1'b1, 0,  0,  2};
      tbl[2]  = '{"clean100", 4'b0011, 33, 0, 1'b1, 0,  0,  2};
      tbl[3]  = '{"miss1",    4'b0000,  1, 0, 1'b1, 0,  1,  2};
      tbl[4]  = '{"clean2",   4'b0011,  9, 0, 1'b1, 0,  0,  2};
      tbl[5]  = '{"glitch3",  4'b0111,  3, 0, 1'b1, 3,  0,  2};
      tbl[6]  = '{"clean3",   4'b0011,  2, 0, 1'b1, 3,  0,  2};
      tbl[7]  = '{"glitch4",  4'b0111,  4, 0, 1'b0, 7,  0, -1};
      tbl[8]  = '{"relock",   4'b0011, 69, 0, 1'b1, 7,  0,  2};
      tbl[9]  = '{"shift",    4'b0011,  4, 1, 1'b0, 11, 0, -1};
      tbl[10] = '{"relock2",  4'b0011, 69, 0, 1'b1, 11, 0,  3};
      tbl[11] = '{"hold0",    4'b0000,  2, 0, 1'b0, 11, 1, -1};
      tbl[12] = '{"relock3",  4'b0011, 69, 0, 1'b1, 11, 0,  3};

      reset = 1'b1;
      encoded_in = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_revo", revo, 0);
      check("rst_locked", locked, 0);
      check("rst_phase", phase, 0);
      check("rst_err", error_count, 0);
      check("rst_period", revo_period, 0);
      check("rst_period_valid", revo_period_valid, 0);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) run_rec(tbl[i]);

      // One marker every 1000 periods while locked.
      r0 = revo_total;
      for (int s = 0; s < 3; s++) begin
`ifdef REVO_PERIOD_MEASURE_EN
         nxt_valid = (s > 0);
`else
         nxt_valid = 1'b0;
`endif
         nxt_per = PW'(1000);
         repeat (999) send_period(4'b0011);
         send_period(4'b0000);
      end
      send_period(4'b0011);
      check("supp_revos", revo_total - r0, 3);
      check("supp_sb_left", sb.size(), 0);
      check("supp_locked", locked, 1);
      nxt_valid = 1'b0;
      nxt_per = '0;

      // Reset pulse landing on a revo strobe.
      repeat (10) send_period(4'b0011);
      send_period(4'b0000);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      check("revo_before_reset", revo, 1);
      reset = 1'b1;
      encoded_in = 1'b0;
      #1;
      check("mid_rst_revo", revo, 0);
      check("mid_rst_locked", locked, 0);
      check("mid_rst_phase", phase, 0);
      check("mid_rst_err", error_count, 0);
      check("mid_rst_period", revo_period, 0);
      check("mid_rst_period_valid", revo_period_valid, 0);
      sb.delete();
      mlocked = 1'b0;
      prev_missing = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      tmp = '{"relock_after_reset", 4'b0011, 69, 0, 1'b1, 0, 0, 2};
      run_rec(tmp);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/revo_decoder.md
REVO_DECODER -- requirements
Module: revo_decoder

Interface
REQ-001 SAMPLES_PER_PERIOD, 4, fast-clock samples per encoded-clock period; fixed at 4 in this revision.
REQ-002 LOCK_COUNT, 64, consecutive good evaluations needed to declare lock.
REQ-003 MAX_ERRORS, 4, consecutive bad evaluations that force loss of lock.
REQ-004 PERIOD_WIDTH, 24, width of the revo period measurement.
REQ-005 clock  input  1  sampling clock at 4x the encoded clock (e.g. 508 MHz against 127 MHz); the only clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 encoded_in  input  1  encoded line: a 50% duty clock with one high pulse suppressed per revolution marker.
REQ-008 revo  output  1  one-cycle strobe per decoded revolution marker.
REQ-009 locked  output  1  high while the decoder is in LOCKED.
REQ-010 phase  output  2  selected sample phase within the encoded period.
REQ-011 error_count  output  8  saturating count of bad windows seen while LOCKED.
REQ-012 revo_period  output  PERIOD_WIDTH  encoded periods between the last two revos.
REQ-013 revo_period_valid  output  1  one-cycle strobe when revo_period updates.

Function
REQ-014 encoded_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized sample.
REQ-015 A 4-bit window SHALL shift in one synchronized sample per clock, newest sample in bit 0; a 2-bit counter SHALL run free 0..3, wrapping.
REQ-016 An evaluation SHALL occur on every cycle where the counter equals the phase register; window 4'b0011 is GOOD, 4'b0000 is MISSING, any other value is BAD.
REQ-017 States: SEARCH, VERIFY, LOCKED; reset enters SEARCH.
REQ-018 SEARCH: on any cycle with window 4'b0011, phase SHALL load the current counter value, the good counter SHALL clear, and the state SHALL go to VERIFY.
REQ-019 VERIFY: GOOD increments the good counter; when it reaches LOCK_COUNT the state SHALL go to LOCKED; MISSING is tolerated once and does not count; BAD, or two consecutive MISSING evaluations, SHALL return to SEARCH.
REQ-020 LOCKED: GOOD clears the consecutive-bad counter; MISSING asserts revo for exactly one cycle, on the cycle after the evaluation; BAD increments error_count (saturating at 255) and the consecutive-bad counter.
REQ-021 LOCKED exits to SEARCH, deasserting locked, on two consecutive MISSING evaluations (no revo for the second) or on the consecutive-bad counter reaching MAX_ERRORS.
REQ-022 revo SHALL never assert outside LOCKED; error_count SHALL hold across relock and clear only on reset.
REQ-023 Latency from the first suppressed-pulse sample at encoded_in to revo SHALL be at most 8 clock cycles and constant while locked.
REQ-024 If BAD and state exit coincide, the error_count increment SHALL still occur.

Reset
REQ-025 Asserting reset SHALL immediately force: state SEARCH, revo 0, locked 0, phase 0, error_count 0, revo_period 0, revo_period_valid 0; synchronizer, window and counters cleared.
REQ-026 Reset asserted mid-operation, including during a revo strobe, SHALL truncate the strobe; after release, the decoder SHALL reacquire from SEARCH.

Configuration
REQ-027 Macro REVO_PERIOD_MEASURE_EN: when defined, a PERIOD_WIDTH counter SHALL increment once per evaluation in LOCKED and saturate at all-ones; on each revo it SHALL load revo_period with its value, pulse revo_period_valid (except on the first revo after entering LOCKED), and restart at 1.
REQ-028 Without REVO_PERIOD_MEASURE_EN: the counter SHALL be absent; revo_period and revo_period_valid SHALL be constant 0.

Verification
REQ-029 Clean 127 MHz pattern, no suppressions, for 100 periods -> locked rises within 66 periods; revo stays 0; error_count 0.
REQ-030 Locked; suppress one pulse every 1000 periods -> one revo per suppression at constant latency; with the macro, revo_period = 1000 from the second revo onward.
REQ-031 Locked; hold encoded_in at 0 -> no revo for the second missing period; locked falls two periods after the line stops.
REQ-032 Locked; inject 3 glitch periods (window 4'b0111) then clean -> error_count = 3 and locked held; inject 4 consecutive -> error_count = 7 and SEARCH.
REQ-033 Assert reset for 1 cycle during a revo strobe -> all outputs 0 at once; relock after 64+ good periods; error_count restarts at 0.
REQ-034 Shift input phase by one fast-clock cycle after lock -> loss of lock, then relock with phase incremented by 1 mod 4.
